operand_loader: RTL

// - Upstream stage of the 2-bit adder datapath: captures operands A and B from 2 switches, one per confirm-button press.
// - Presents both operands with a valid flag; the adder consumes op_a/op_b combinationally.
// - Debounced, edge-detected buttons so that one press gives exactly one capture; the clear button restarts entry.

---
 rtl/operand_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/operand_loader.sv
// Operand entry stage for the 2-bit adder: two confirm presses capture A then B from the switches.
// Define DEBOUNCE_EN to add per-button debounce counters; without it the synchronized level is used directly.
module operand_loader #(
  parameter int DEB_CYCLES = 250000,
  parameter bit BTN_POL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sw,
  input  logic       btn_ok,
  input  logic       btn_clr,
  output logic [1:0] op_a,
  output logic [1:0] op_b,
  output logic       op_valid,
  output logic [1:0] stage
);

  // Handshake: op_valid is a level, high exactly while stage is READY; op_a/op_b are
  // frozen for that whole interval and the adder may sample them on any cycle.

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } stage_t;

  localparam logic BtnIdle = ~BTN_POL;

  if (DEB_CYCLES < 1) begin : gDebRangeCheck
    $error("operand_loader: DEB_CYCLES must be at least 1");
  end

  logic [1:0] swMeta, swSync;
  logic [1:0] okSyncQ, clrSyncQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swMeta   <= 2'b00;
      swSync   <= 2'b00;
      okSyncQ  <= {2{BtnIdle}};
      clrSyncQ <= {2{BtnIdle}};
    end else begin
      swMeta   <= sw;
      swSync   <= swMeta;
      okSyncQ  <= {okSyncQ[0], btn_ok};
      clrSyncQ <= {clrSyncQ[0], btn_clr};
    end
  end

  // Buttons are active-high from here on regardless of pin polarity.
  logic okLvl, clrLvl;
  assign okLvl  = ~(okSyncQ[1] ^ BTN_POL);
  assign clrLvl = ~(clrSyncQ[1] ^ BTN_POL);

  logic okDeb, clrDeb;

`ifdef DEBOUNCE_EN
  localparam int CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] okCnt, clrCnt;

  // A level only flips after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      okCnt  <= '0;
      clrCnt <= '0;
      okDeb  <= 1'b0;
      clrDeb <= 1'b0;
    end else begin
      if (okLvl == okDeb) begin
        okCnt <= '0;
      end else if (okCnt == CntLast) begin
        okDeb <= okLvl;
        okCnt <= '0;
      end else begin
        okCnt <= okCnt + CntOne;
      end

      if (clrLvl == clrDeb) begin
        clrCnt <= '0;
      end else if (clrCnt == CntLast) begin
        clrDeb <= clrLvl;
        clrCnt <= '0;
      end else begin
        clrCnt <= clrCnt + CntOne;
      end
    end
  end
`else
  assign okDeb  = okLvl;
  assign clrDeb = clrLvl;
`endif

  logic okPrev, clrPrev;
  logic okP, clrP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      okPrev  <= 1'b0;
      clrPrev <= 1'b0;
    end else begin
      okPrev  <= okDeb;
      clrPrev <= clrDeb;
    end
  end

  assign okP  = okDeb & ~okPrev;
  assign clrP = clrDeb & ~clrPrev;

  stage_t     stageQ;
  logic [1:0] opAQ, opBQ;
  logic       validQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stageQ <= LOAD_A;
      opAQ   <= 2'b00;
      opBQ   <= 2'b00;
      validQ <= 1'b0;
    end else if (clrP) begin
      // Clear outranks a confirm arriving in the same cycle.
      stageQ <= LOAD_A;
      opAQ   <= 2'b00;
      opBQ   <= 2'b00;
      validQ <= 1'b0;
    end else begin
      case (stageQ)
        LOAD_A: begin
          if (okP) begin
            opAQ   <= swSync;
            stageQ <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (okP) begin
            opBQ   <= swSync;
            validQ <= 1'b1;
            stageQ <= READY;
          end
        end
        READY: begin
          // A new press starts the next operation; B survives until recaptured.
          if (okP) begin
            opAQ   <= swSync;
            validQ <= 1'b0;
            stageQ <= LOAD_B;
          end
        end
        default: begin
          stageQ <= LOAD_A;
          opAQ   <= 2'b00;
          opBQ   <= 2'b00;
          validQ <= 1'b0;
        end
      endcase
    end
  end

  assign op_a     = opAQ;
  assign op_b     = opBQ;
  assign op_valid = validQ;
  assign stage    = stageQ;

endmodule
